// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data memory between the fetch
// unit (I) and the load/store unit (D). Each requester has a valid/ready
// request channel and a valid/ready response channel. Only one transaction is
// in flight at a time. When both requesters ask in the same cycle, the one
// that was not granted last wins (round-robin).
//
// Transaction flow: IDLE (accept) -> ACCESS (drive memory, capture read data)
// -> RESP (hold response until consumed) -> IDLE.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   i_req_valid/ready/addr         fetch request channel
//   i_rsp_valid/ready/data/err     fetch response channel
//   d_req_valid/ready/addr/we/wdata  load/store request channel
//   d_rsp_valid/ready/data/err     load/store response channel (data 0 for stores)
//   mem_addr/wr_en/wr_data         memory drive (byte address)
//   mem_rd_data                    memory asynchronous read data
//
// Optional feature macro: MEM_PORT_ARB_ALIGN_CHK_EN
//   When defined, a byte address with addr[1:0] != 0 is rejected like an
//   out-of-range address (no write, data 0, err 1). When undefined, addr[1:0]
//   is ignored and only out-of-range addresses raise err.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] i_rsp_data,
    output logic              i_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // One extra bit so the byte limit never wraps for any ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS) << 2;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic                grant_i, grant_d;
    logic                in_range;
    logic                access_err;
    logic                rsp_taken;

    // Arbitration: only in IDLE and never while reset is asserted, so nothing
    // can be accepted in the same cycle the block is being reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (i_req_valid && d_req_valid) begin
                grant_d = (last_grant_q == OWN_I);
                grant_i = !grant_d;
            end else begin
                grant_i = i_req_valid;
                grant_d = d_req_valid;
            end
        end
    end

    assign in_range = ({1'b0, addr_q} < ADDR_LIMIT);

`ifdef MEM_PORT_ARB_ALIGN_CHK_EN
    assign access_err = !in_range || (addr_q[1:0] != 2'b00);
`else
    assign access_err = !in_range;
`endif

    assign rsp_taken = (owner_q == OWN_D) ? d_rsp_ready : i_rsp_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_i || grant_d) begin
                    owner_d      = grant_d ? OWN_D : OWN_I;
                    last_grant_d = grant_d ? OWN_D : OWN_I;
                    addr_d       = grant_d ? d_req_addr : i_req_addr;
                    we_d         = grant_d && d_req_we;
                    wdata_d      = grant_d ? d_req_wdata : '0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                // Stores and rejected accesses return zero data.
                rsp_err_d  = access_err;
                rsp_data_d = (we_q || access_err) ? '0 : mem_rd_data;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_taken) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_I;
            owner_q      <= OWN_I;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    assign i_rsp_valid = (state_q == RESP) && (owner_q == OWN_I) && !reset;
    assign d_rsp_valid = (state_q == RESP) && (owner_q == OWN_D) && !reset;
    assign i_rsp_data  = rsp_data_q;
    assign d_rsp_data  = rsp_data_q;
    assign i_rsp_err   = rsp_err_q;
    assign d_rsp_err   = rsp_err_q;

    // The memory sees the latched address at all times; the write strobe is
    // confined to ACCESS and dropped immediately if reset arrives mid-store.
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign mem_wr_en   = (state_q == ACCESS) && we_q && !access_err && !reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a small behavioural memory. The
// stimulus process pushes each expected response into a per-port queue; a
// monitor on the falling edge pops and compares on every response handshake.
// Expected grant order for the contention test goes through a queue the same
// way. Directed spot checks cover reset values, latency and hold stability.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req_valid, i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid, i_rsp_ready;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;
    logic        d_req_valid, d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid, d_rsp_ready;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MEM_WORDS(1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req_valid(i_req_valid),
        .i_req_ready(i_req_ready),
        .i_req_addr (i_req_addr),
        .i_rsp_valid(i_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .i_rsp_data (i_rsp_data),
        .i_rsp_err  (i_rsp_err),
        .d_req_valid(d_req_valid),
        .d_req_ready(d_req_ready),
        .d_req_addr (d_req_addr),
        .d_req_we   (d_req_we),
        .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid),
        .d_rsp_ready(d_rsp_ready),
        .d_rsp_data (d_rsp_data),
        .d_rsp_err  (d_rsp_err),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: async read, write on posedge. Out-of-range reads
    // return a poison pattern so the DUT must substitute zero itself.
    logic [31:0] mem [0:1023];
    logic        load_mem;

    assign mem_rd_data = (mem_addr < 32'h1000) ? mem[mem_addr[11:2]] : 32'hA5A5_A5A5;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'h0;
            mem[0] <= 32'h0050_0093;
            mem[5] <= 32'h1234_5678;
        end else if (mem_wr_en && mem_addr < 32'h1000) begin
            mem[mem_addr[11:2]] <= mem_wr_data;
        end
    end

    int pass_cnt  = 0;
    int total_cnt = 0;
    int wr_cnt    = 0;

    logic [32:0] i_exp_q[$];   // {err, data}
    logic [32:0] d_exp_q[$];
    logic        grant_exp_q[$]; // 0 = I, 1 = D

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total_cnt++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: response scoreboard, grant order, write-strobe counting.
    always @(negedge clk) begin
        logic [32:0] e;
        logic        g;
        if (mem_wr_en) wr_cnt++;
        if (i_rsp_valid && i_rsp_ready) begin
            if (i_exp_q.size() == 0) begin
                timeout("i_rsp_unexpected");
            end else begin
                e = i_exp_q.pop_front();
                chk("i_rsp_data", i_rsp_data, e[31:0]);
                chk("i_rsp_err", {31'b0, i_rsp_err}, {31'b0, e[32]});
                $display("I rsp: data=0x%08h err=%0d", i_rsp_data, i_rsp_err);
            end
        end
        if (d_rsp_valid && d_rsp_ready) begin
            if (d_exp_q.size() == 0) begin
                timeout("d_rsp_unexpected");
            end else begin
                e = d_exp_q.pop_front();
                chk("d_rsp_data", d_rsp_data, e[31:0]);
                chk("d_rsp_err", {31'b0, d_rsp_err}, {31'b0, e[32]});
                $display("D rsp: data=0x%08h err=%0d", d_rsp_data, d_rsp_err);
            end
        end
        if ((i_req_ready || d_req_ready) && grant_exp_q.size() > 0) begin
            g = grant_exp_q.pop_front();
            chk("grant_order", {31'b0, d_req_ready}, {31'b0, g});
        end
    end

    task automatic do_i(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
        int n;
        i_exp_q.push_back({exp_err, exp_data});
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        n = 0;
        @(negedge clk);
        while (!i_req_ready && n < 40) begin @(negedge clk); n++; end
        if (!i_req_ready) begin timeout("i_req_accept"); i_req_valid = 1'b0; return; end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(i_rsp_valid && i_rsp_ready) && n < 40) begin @(negedge clk); n++; end
        if (!(i_rsp_valid && i_rsp_ready)) timeout("i_rsp_wait");
        @(posedge clk); #1;
    endtask

    task automatic do_d(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
        int n;
        d_exp_q.push_back({exp_err, exp_data});
        d_req_valid = 1'b1;
        d_req_addr  = addr;
        d_req_we    = we;
        d_req_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!d_req_ready && n < 40) begin @(negedge clk); n++; end
        if (!d_req_ready) begin timeout("d_req_accept"); d_req_valid = 1'b0; return; end
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(d_rsp_valid && d_rsp_ready) && n < 40) begin @(negedge clk); n++; end
        if (!(d_rsp_valid && d_rsp_ready)) timeout("d_rsp_wait");
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int w0;
        int n;
        reset       = 1'b1;
        load_mem    = 1'b1;
        i_req_valid = 1'b0;
        i_req_addr  = 32'h0;
        i_rsp_ready = 1'b1;
        d_req_valid = 1'b0;
        d_req_addr  = 32'h0;
        d_req_we    = 1'b0;
        d_req_wdata = 32'h0;
        d_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 load_mem = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_i_req_ready", {31'b0, i_req_ready}, 32'h0);
        chk("rst_d_req_ready", {31'b0, d_req_ready}, 32'h0);
        chk("rst_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
        chk("rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);
        chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp_data", d_rsp_data, 32'h0);
        chk("rst_rsp_err", {31'b0, i_rsp_err}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // First fetch with latency checks.
        i_exp_q.push_back({1'b0, 32'h0050_0093});
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0;
        @(negedge clk);
        chk("fetch_ready_same_cycle", {31'b0, i_req_ready}, 32'h1);
        @(posedge clk); #1 i_req_valid = 1'b0;
        @(negedge clk);
        chk("fetch_rsp_not_yet", {31'b0, i_rsp_valid}, 32'h0);
        chk("fetch_req_ready_busy", {31'b0, i_req_ready}, 32'h0);
        @(negedge clk);
        chk("fetch_rsp_at_n2", {31'b0, i_rsp_valid}, 32'h1);
        @(posedge clk); #1;
        $display("I fetch 0x0 done");

        // Store then load.
        w0 = wr_cnt;
        do_d(32'h10, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        chk("store_wr_en_cycles", wr_cnt - w0, 32'd1);
        chk("store_mem_content", mem[4], 32'hDEAD_BEEF);
        $display("D store 0x10 done");
        do_d(32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        $display("D load 0x10 done");

        // Contention after reset: D, I, D, I.
        pulse_reset();
        grant_exp_q.push_back(1'b1);
        grant_exp_q.push_back(1'b0);
        grant_exp_q.push_back(1'b1);
        grant_exp_q.push_back(1'b0);
        fork
            begin
                do_d(32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
                do_d(32'h0,  1'b0, 32'h0, 32'h0050_0093, 1'b0);
            end
            begin
                do_i(32'h14, 32'h1234_5678, 1'b0);
                do_i(32'h10, 32'hDEAD_BEEF, 1'b0);
            end
        join
        chk("grant_queue_drained", grant_exp_q.size(), 32'd0);
        $display("contention sequence done");

        // Out of range.
        w0 = wr_cnt;
        do_d(32'h1000, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b1);
        chk("oor_store_no_wr", wr_cnt - w0, 32'd0);
        do_d(32'h1000, 1'b0, 32'h0, 32'h0, 1'b1);
        do_i(32'h2000, 32'h0, 1'b1);
        $display("out-of-range accesses done");

        // Backpressure on the D response while I waits.
        d_rsp_ready = 1'b0;
        d_exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        d_req_valid = 1'b1;
        d_req_addr  = 32'h10;
        d_req_we    = 1'b0;
        n = 0;
        @(negedge clk);
        while (!d_req_ready && n < 40) begin @(negedge clk); n++; end
        if (!d_req_ready) timeout("hold_accept");
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0;
        n = 0;
        @(negedge clk);
        while (!d_rsp_valid && n < 40) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            chk("hold_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h1);
            chk("hold_d_rsp_data", d_rsp_data, 32'hDEAD_BEEF);
            chk("hold_i_req_ready", {31'b0, i_req_ready}, 32'h0);
            @(negedge clk);
        end
        @(posedge clk); #1 d_rsp_ready = 1'b1;
        do_i(32'h0, 32'h0050_0093, 1'b0);
        $display("backpressure sequence done");

        // Reset during ACCESS of a store.
        w0 = wr_cnt;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h20;
        d_req_we    = 1'b1;
        d_req_wdata = 32'h1111_1111;
        n = 0;
        @(negedge clk);
        while (!d_req_ready && n < 40) begin @(negedge clk); n++; end
        if (!d_req_ready) timeout("rst_mid_accept");
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        chk("rst_mid_wr_en", {31'b0, mem_wr_en}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", {31'b0, d_rsp_valid}, 32'h0);
        end
        chk("rst_mid_no_write", wr_cnt - w0, 32'd0);
        chk("rst_mid_mem", mem[8], 32'h0);
        @(posedge clk); #1;
        do_i(32'h14, 32'h1234_5678, 1'b0);
        $display("reset mid-store done");

        // Misaligned load.
`ifdef MEM_PORT_ARB_ALIGN_CHK_EN
        do_d(32'h2, 1'b0, 32'h0, 32'h0, 1'b1);
`else
        do_d(32'h2, 1'b0, 32'h0, 32'h0050_0093, 1'b0);
`endif
        $display("D load 0x2 done");

        repeat (2) @(negedge clk);
        chk("i_queue_drained", i_exp_q.size(), 32'd0);
        chk("d_queue_drained", d_exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
